// File: rtl/ysyx_22050710_mdu_ctrl_pkg.sv
// Shared definitions for the M-extension sequencer:
// widths, ALUctr codes, FSM states, sign-extension helper.
package ysyx_22050710_mdu_ctrl_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b11001;
  localparam logic [4:0] OP_MULHSU = 5'b11010;
  localparam logic [4:0] OP_MULHU  = 5'b11011;
  localparam logic [4:0] OP_DIV    = 5'b01011;
  localparam logic [4:0] OP_DIVU   = 5'b01100;
  localparam logic [4:0] OP_REM    = 5'b01101;
  localparam logic [4:0] OP_REMU   = 5'b01110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] sext32(
    input logic [31:0] v
  );
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22050710_mdu_ctrl_if.sv
// Request/response bundle between EXU and the MDU.
// Names follow the sequencer's port list.
interface ysyx_22050710_mdu_ctrl_if;
  import ysyx_22050710_mdu_ctrl_pkg::*;

  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_ALUctr;
  logic            i_word_cut;
  logic [XLEN-1:0] i_src1;
  logic [XLEN-1:0] i_src2;
  logic            i_flush;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport master (
    output i_valid, i_ALUctr, i_word_cut,
    output i_src1, i_src2, i_flush, i_out_ready,
    input  o_ready, o_out_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_ALUctr, i_word_cut,
    input  i_src1, i_src2, i_flush, i_out_ready,
    output o_ready, o_out_valid, o_result, o_busy
  );

endinterface

// File: rtl/ysyx_22050710_mdu_iter.sv
// One-bit-per-cycle datapath: shift-add multiply or
// restoring shift-subtract divide on unsigned magnitudes.
module ysyx_22050710_mdu_iter
  import ysyx_22050710_mdu_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] op_i,
  output logic [XLEN-1:0] nhi_o,
  output logic [XLEN-1:0] nlo_o
);

  logic [XLEN-1:0] hi_q, lo_q, op_q;
  logic [XLEN-1:0] hi_d, lo_d;
  logic            div_q;
  logic [XLEN:0]   sum, rs, diff;
  logic            ge;

  // Single step: add-then-shift-right, or shift-left-then-trial-subtract
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
    rs   = {hi_q, lo_q[XLEN-1]};
    diff = rs - {1'b0, op_q};
    ge   = ~diff[XLEN];
    hi_d = sum[XLEN:1];
    lo_d = {sum[0], lo_q[XLEN-1:1]};
    if (div_q) begin
      hi_d = ge ? diff[XLEN-1:0] : rs[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ge};
    end
  end

  // Partial/operand registers: load on accept, advance while stepping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      op_q  <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      hi_q  <= '0;
      lo_q  <= lo_i;
      op_q  <= op_i;
      div_q <= div_i;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign nhi_o = hi_d;
  assign nlo_o = lo_d;

endmodule

// File: rtl/ysyx_22050710_mdu_ctrl.sv
// M-extension sequencer: FSM, sign handling, fast paths.
// YSYX_22050710_MDU_WORD_FAST_EN: W ops iterate 32 steps.
module ysyx_22050710_mdu_ctrl
  import ysyx_22050710_mdu_ctrl_pkg::*;
(
  input logic i_clk,
  input logic i_rst,
  ysyx_22050710_mdu_ctrl_if.slave bus
);

  localparam int PW = 2 * XLEN;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             load, step, last;

  logic is_mul, is_div, is_mdu, is_rem;
  logic hi_sel, sgn_a, sgn_b, word, wf;
  logic neg_a, neg_b, neg_r;
  logic div0, ovf, fast;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;
  logic [XLEN-1:0] min_v, fast_raw, fast_val;
  logic [XLEN-1:0] lo_init, op_init;

  logic hi_sel_q, div_q, rem_q;
  logic word_q, wf_q, neg_q;

  logic [XLEN-1:0] nh, nl;
  logic [PW-1:0]   prod, prod_a, prod_s;
  logic [XLEN-1:0] mul_r, dv, dv_s, raw, fin;

  // Decode the ALUctr code into operation class and signedness
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    is_rem = 1'b0;
    hi_sel = 1'b0;
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    case (bus.i_ALUctr)
      OP_MUL:    is_mul = 1'b1;
      OP_MULH: begin
        is_mul = 1'b1;
        hi_sel = 1'b1;
        sgn_a  = 1'b1;
        sgn_b  = 1'b1;
      end
      OP_MULHSU: begin
        is_mul = 1'b1;
        hi_sel = 1'b1;
        sgn_a  = 1'b1;
      end
      OP_MULHU: begin
        is_mul = 1'b1;
        hi_sel = 1'b1;
      end
      OP_DIV: begin
        is_div = 1'b1;
        sgn_a  = 1'b1;
        sgn_b  = 1'b1;
      end
      OP_DIVU:   is_div = 1'b1;
      OP_REM: begin
        is_div = 1'b1;
        is_rem = 1'b1;
        sgn_a  = 1'b1;
        sgn_b  = 1'b1;
      end
      OP_REMU: begin
        is_div = 1'b1;
        is_rem = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_mdu = is_mul | is_div;
  assign word   = bus.i_word_cut;

`ifdef YSYX_22050710_MDU_WORD_FAST_EN
  assign wf = word;
`else
  assign wf = 1'b0;
`endif

  // Operand extension, magnitudes and fast-path detection
  always_comb begin
    a_ext = bus.i_src1;
    b_ext = bus.i_src2;
    if (word) begin
      a_ext = sgn_a ? sext32(bus.i_src1[31:0])
                    : {32'b0, bus.i_src1[31:0]};
      b_ext = sgn_b ? sext32(bus.i_src2[31:0])
                    : {32'b0, bus.i_src2[31:0]};
    end
    neg_a = sgn_a & a_ext[XLEN-1];
    neg_b = sgn_b & b_ext[XLEN-1];
    mag_a = neg_a ? -a_ext : a_ext;
    mag_b = neg_b ? -b_ext : b_ext;
    neg_r = is_rem ? neg_a : (neg_a ^ neg_b);
    min_v = word ? {{(XLEN-31){1'b1}}, 31'b0}
                 : {1'b1, {(XLEN-1){1'b0}}};
    div0  = is_div & (b_ext == '0);
    ovf   = is_div & sgn_a & (a_ext == min_v)
          & (b_ext == '1);
    fast  = ~is_mdu | div0 | ovf;
    fast_raw = '0;
    if (div0)
      fast_raw = is_rem ? a_ext : '1;
    else if (ovf)
      fast_raw = is_rem ? '0 : a_ext;
    fast_val = word ? sext32(fast_raw[31:0]) : fast_raw;
    if (is_div) begin
      lo_init = wf ? {mag_a[31:0], 32'b0} : mag_a;
      op_init = mag_b;
    end else begin
      lo_init = wf ? {32'b0, mag_b[31:0]} : mag_b;
      op_init = mag_a;
    end
  end

  // Sign fix-up and result selection from the final step
  always_comb begin
    prod   = {nh, nl};
    prod_a = wf_q ? {32'b0, prod[PW-1:32]} : prod;
    prod_s = neg_q ? -prod_a : prod_a;
    mul_r  = hi_sel_q ? prod_s[PW-1:XLEN]
                      : prod_s[XLEN-1:0];
    dv     = rem_q ? nh : nl;
    dv_s   = neg_q ? -dv : dv;
    raw    = div_q ? dv_s : mul_r;
    fin    = word_q ? sext32(raw[31:0]) : raw;
  end

  assign last = (cnt_q == (wf_q ? CNT_W'(31)
                                : CNT_W'(XLEN-1)));

  // Next-state, counter and result update; flush wins
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          load  = 1'b1;
          cnt_d = '0;
          if (fast) begin
            state_d  = ST_DONE;
            result_d = fast_val;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = fin;
        end
      end
      ST_DONE: begin
        if (bus.i_out_ready) begin
          state_d  = ST_IDLE;
          result_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.i_flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = '0;
      load     = 1'b0;
      step     = 1'b0;
    end
  end

  // FSM, counter and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Per-operation attributes captured at accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hi_sel_q <= 1'b0;
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
      word_q   <= 1'b0;
      wf_q     <= 1'b0;
      neg_q    <= 1'b0;
    end else if (load) begin
      hi_sel_q <= hi_sel;
      div_q    <= is_div;
      rem_q    <= is_rem;
      word_q   <= word;
      wf_q     <= wf;
      neg_q    <= neg_r;
    end
  end

  ysyx_22050710_mdu_iter u_iter (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .load_i (load),
    .step_i (step),
    .div_i  (is_div),
    .lo_i   (lo_init),
    .op_i   (op_init),
    .nhi_o  (nh),
    .nlo_o  (nl)
  );

  assign bus.o_ready     = (state_q == ST_IDLE);
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_out_valid = (state_q == ST_DONE);
  assign bus.o_result    = result_q;

endmodule

// File: tb/tb_ysyx_22050710_mdu_ctrl.sv
// Directed bench for the M-extension sequencer.
// Expected values are hand-computed constants.
module tb_ysyx_22050710_mdu_ctrl;
  import ysyx_22050710_mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam int LAT = XLEN + 1;
`ifdef YSYX_22050710_MDU_WORD_FAST_EN
  localparam int WLAT = 33;
`else
  localparam int WLAT = XLEN + 1;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] XV   = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  ysyx_22050710_mdu_ctrl_if bus();

  ysyx_22050710_mdu_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ctl();
    return {61'b0, bus.o_ready, bus.o_busy,
            bus.o_out_valid};
  endfunction

  task automatic run(input string tag,
                     input logic [4:0] c,
                     input logic w,
                     input logic [63:0] a,
                     input logic [63:0] b,
                     input logic [63:0] exp,
                     input int elat,
                     input int hold);
    int lat;
    bus.i_ALUctr   = c;
    bus.i_word_cut = w;
    bus.i_src1     = a;
    bus.i_src2     = b;
    bus.i_valid    = 1'b1;
    chk({tag, " ready"}, ctl(), 64'b100);
    tick();
    bus.i_src1     = ~a;
    bus.i_src2     = b + 64'd5;
    bus.i_ALUctr   = OP_MULHU;
    bus.i_word_cut = ~w;
    lat = 1;
    while (!bus.o_out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, " lat"}, 64'(lat), 64'(elat));
    chk({tag, " res"}, bus.o_result, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " hold ctl"}, ctl(), 64'b011);
      chk({tag, " hold res"}, bus.o_result, exp);
    end
    bus.i_valid     = 1'b0;
    bus.i_out_ready = 1'b1;
    tick();
    chk({tag, " release"}, ctl(), 64'b100);
    bus.i_out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    bus.i_valid     = 1'b0;
    bus.i_ALUctr    = 5'b0;
    bus.i_word_cut  = 1'b0;
    bus.i_src1      = '0;
    bus.i_src2      = '0;
    bus.i_flush     = 1'b0;
    bus.i_out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset ctl", ctl(), 64'b100);
    chk("reset res", bus.o_result, 64'd0);
    rst = 1'b0;
    tick();

    run("mul", OP_MUL, 1'b0, 64'd7,
        64'hFFFF_FFFF_FFFF_FFFD,
        64'hFFFF_FFFF_FFFF_FFEB, LAT, 5);
    run("mulhu", OP_MULHU, 1'b0, ONES, 64'd2,
        64'd1, LAT, 0);
    run("mulh", OP_MULH, 1'b0, ONES, ONES,
        64'd0, LAT, 0);
    run("mulhsu", OP_MULHSU, 1'b0, ONES, 64'd2,
        ONES, LAT, 0);
    run("div", OP_DIV, 1'b0,
        64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, LAT, 0);
    run("rem", OP_REM, 1'b0,
        64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
        ONES, LAT, 0);
    run("divu", OP_DIVU, 1'b0, 64'd100, 64'd7,
        64'd14, LAT, 0);
    run("remu", OP_REMU, 1'b0, 64'd100, 64'd7,
        64'd2, LAT, 0);
    run("divu0", OP_DIVU, 1'b0, XV, 64'd0,
        ONES, 1, 0);
    run("rem0", OP_REM, 1'b0, XV, 64'd0,
        XV, 1, 0);
    run("divovf", OP_DIV, 1'b0, MIN, ONES,
        MIN, 1, 0);
    run("divw_ovf", OP_DIV, 1'b1,
        64'h0000_0000_8000_0000, ONES,
        64'hFFFF_FFFF_8000_0000, 1, 0);
    run("mulw", OP_MUL, 1'b1,
        64'h0000_0001_0000_0002, 64'd3,
        64'd6, WLAT, 0);
    run("divw", OP_DIV, 1'b1,
        64'h0000_0000_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, WLAT, 0);
    run("remuw", OP_REMU, 1'b1,
        64'h0000_0000_FFFF_FFFF, 64'd10,
        64'd5, WLAT, 0);
    run("nonmdu", 5'b00000, 1'b0, 64'd5, 64'd6,
        64'd0, 1, 0);

    bus.i_ALUctr   = OP_DIVU;
    bus.i_word_cut = 1'b0;
    bus.i_src1     = 64'd100;
    bus.i_src2     = 64'd7;
    bus.i_valid    = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    repeat (9) tick();
    chk("calc busy", ctl(), 64'b010);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("flush ctl", ctl(), 64'b100);
    chk("flush res", bus.o_result, 64'd0);
    seen = 0;
    repeat (70) begin
      tick();
      if (bus.o_out_valid) seen++;
    end
    chk("flush quiet", 64'(seen), 64'd0);

    bus.i_ALUctr = OP_MUL;
    bus.i_valid  = 1'b1;
    bus.i_flush  = 1'b1;
    tick();
    chk("flush idle", ctl(), 64'b100);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    tick();
    chk("flush idle2", ctl(), 64'b100);

    bus.i_ALUctr = OP_MUL;
    bus.i_src1   = 64'd7;
    bus.i_src2   = 64'd3;
    bus.i_valid  = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst ctl", ctl(), 64'b100);
    chk("midrst res", bus.o_result, 64'd0);
    seen = 0;
    repeat (70) begin
      tick();
      if (bus.o_out_valid) seen++;
    end
    chk("midrst quiet", 64'(seen), 64'd0);

    run("after", OP_DIVU, 1'b0, 64'd100, 64'd7,
        64'd14, LAT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
